// File: rtl/button_conditioner.sv
// Button conditioner: per-button 2-flop synchronizer, debounce counter and press pulse
// for the elevator controller's in-car and hall button inputs.
module button_conditioner #(
  parameter int N_IN            = 6,
  parameter int N_OUT           = 10,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  raw_in,
  input  logic [N_OUT-1:0] raw_out,
  output logic [N_IN-1:0]  level_in,
  output logic [N_OUT-1:0] level_out,
  output logic [N_IN-1:0]  press_in,
  output logic [N_OUT-1:0] press_out,
  output logic             any_press
);

  localparam int N = N_IN + N_OUT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic STABLE0 = 1'b0;
  localparam logic STABLE1 = 1'b1;

  logic [N-1:0]            raw_all;
  logic [N-1:0]            sync_p0;
  logic [N-1:0]            sync_p1;
  logic [N-1:0]            state;
  logic [N-1:0]            state_nxt;
  logic [N-1:0][CNT_W-1:0] cnt;
  logic [N-1:0][CNT_W-1:0] cnt_nxt;
  logic [N-1:0]            press;
  logic [N-1:0]            press_nxt;
  logic                    any_nxt;

  // Channels 0..N_IN-1 are in-car buttons, the rest are hall buttons.
  assign raw_all = {raw_out, raw_in};

  // Stage p0 -> p1: two-flop synchronizer; only sync_p1 feeds the debouncer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_all;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p1 -> debounced state: registers for state, counters, pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= {N{STABLE0}};
      cnt       <= '0;
      press     <= '0;
      any_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press     <= press_nxt;
      any_press <= any_nxt;
    end
  end

  // Any return of the synchronized input to the accepted level restarts the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    for (int i = 0; i < N; i++) begin
      if (sync_p1[i] != state[i]) begin
        if (cnt[i] == CNT_LAST) begin
          state_nxt[i] = ~state[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pulses are derived from the next state so they align with the level change.
  always_comb begin
    press_nxt = '0;
    for (int i = 0; i < N; i++) begin
      press_nxt[i] = (state[i] == STABLE0) && (state_nxt[i] == STABLE1);
    end
    any_nxt = |press_nxt;
  end

  assign level_in  = state[N_IN-1:0];
  assign level_out = state[N-1:N_IN];
  assign press_in  = press[N_IN-1:0];
  assign press_out = press[N-1:N_IN];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table-driven vectors on a DEBOUNCE_CYCLES=4
// instance plus hand-written sequences on a DEBOUNCE_CYCLES=1 instance.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] raw_in, level_in, press_in;
  logic [9:0] raw_out, level_out, press_out;
  logic       any_press;

  logic [5:0] raw_in1, level_in1, press_in1;
  logic [9:0] raw_out1, level_out1, press_out1;
  logic       any_press1;

  button_conditioner #(.N_IN(6), .N_OUT(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .raw_out(raw_out),
    .level_in(level_in), .level_out(level_out), .press_in(press_in),
    .press_out(press_out), .any_press(any_press)
  );

  button_conditioner #(.N_IN(6), .N_OUT(10), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .raw_in(raw_in1), .raw_out(raw_out1),
    .level_in(level_in1), .level_out(level_out1), .press_in(press_in1),
    .press_out(press_out1), .any_press(any_press1)
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic [5:0] rin;
    logic [9:0] rout;
    logic [5:0] lin;
    logic [9:0] lout;
    logic [5:0] pin;
    logic [9:0] pout;
    logic       any;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string tag, input logic r, input logic [5:0] rin,
                     input logic [9:0] rout, input logic [5:0] lin,
                     input logic [9:0] lout, input logic [5:0] pin,
                     input logic [9:0] pout, input logic any);
    vec_t v;
    v.tag = tag; v.rst = r; v.rin = rin; v.rout = rout;
    v.lin = lin; v.lout = lout; v.pin = pin; v.pout = pout; v.any = any;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] outs4();
    return {level_in, level_out, press_in, press_out, any_press};
  endfunction

  task automatic step1(input string name, input logic l, input logic p);
    @(posedge clk);
    #1;
    check(name, {30'd0, level_in1[0], press_in1[0], any_press1}, {30'd0, l, p, p});
  endtask

  initial begin
    rst      = 1'b0;
    raw_in   = '0;
    raw_out  = '0;
    raw_in1  = '0;
    raw_out1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs4(), 33'd0);
    check("reset_state_d1", {level_in1, level_out1, press_in1, press_out1, any_press1}, 33'd0);
    rst = 1'b1;

    // Single rise on raw_in[2], held, then released before edge 8
    for (int i = 0; i < 14; i++)
      add("single", 1'b1, (i < 8) ? 6'b000100 : 6'd0, 10'd0,
          (i >= 5 && i < 13) ? 6'b000100 : 6'd0, 10'd0,
          (i == 5) ? 6'b000100 : 6'd0, 10'd0, i == 5);

    // Bounce on raw_out[7]: 3 high / 2 low, three times, then quiet
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 5; k++)
        add("bounce", 1'b1, 6'd0, (k < 3) ? 10'h080 : 10'd0,
            6'd0, 10'd0, 6'd0, 10'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      add("bounce_q", 1'b1, 6'd0, 10'd0, 6'd0, 10'd0, 6'd0, 10'd0, 1'b0);

    // raw_in[0] and raw_out[9] rise together
    for (int i = 0; i < 14; i++)
      add("simul", 1'b1, (i < 8) ? 6'b000001 : 6'd0, (i < 8) ? 10'h200 : 10'd0,
          (i >= 5 && i < 13) ? 6'b000001 : 6'd0, (i >= 5 && i < 13) ? 10'h200 : 10'd0,
          (i == 5) ? 6'b000001 : 6'd0, (i == 5) ? 10'h200 : 10'd0, i == 5);

    // raw_in[3] held 100 clocks then released: one pulse, level falls 5 edges later
    for (int i = 0; i < 110; i++)
      add("hold", 1'b1, (i < 100) ? 6'b001000 : 6'd0, 10'd0,
          (i >= 5 && i < 105) ? 6'b001000 : 6'd0, 10'd0,
          (i == 5) ? 6'b001000 : 6'd0, 10'd0, i == 5);

    // Reset mid-count: raw_out[0] already debounced high, raw_in[1] counting
    for (int i = 0; i < 7; i++)
      add("pre_rst", 1'b1, 6'd0, 10'h001, 6'd0, (i >= 5) ? 10'h001 : 10'd0,
          6'd0, (i == 5) ? 10'h001 : 10'd0, i == 5);
    for (int j = 0; j < 4; j++)
      add("count", 1'b1, 6'b000010, 10'h001, 6'd0, 10'h001, 6'd0, 10'd0, 1'b0);
    for (int j = 0; j < 3; j++)
      add("in_rst", 1'b0, 6'b000010, 10'h001, 6'd0, 10'd0, 6'd0, 10'd0, 1'b0);
    for (int k = 1; k <= 8; k++)
      add("post_rst", 1'b1, 6'b000010, 10'h001,
          (k >= 6) ? 6'b000010 : 6'd0, (k >= 6) ? 10'h001 : 10'd0,
          (k == 6) ? 6'b000010 : 6'd0, (k == 6) ? 10'h001 : 10'd0, k == 6);

    for (int i = 0; i < vq.size(); i++) begin
      rst     = vq[i].rst;
      raw_in  = vq[i].rin;
      raw_out = vq[i].rout;
      #1;
      if (!vq[i].rst)
        check($sformatf("%s_async[%0d]", vq[i].tag, i), outs4(), 33'd0);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", vq[i].tag, i), outs4(),
            {vq[i].lin, vq[i].lout, vq[i].pin, vq[i].pout, vq[i].any});
    end

    // DEBOUNCE_CYCLES=1: rise accepted at edge 2, release at edge 2
    raw_in1 = 6'b000001;
    step1("d1_rise_e0", 1'b0, 1'b0);
    step1("d1_rise_e1", 1'b0, 1'b0);
    step1("d1_rise_e2", 1'b1, 1'b1);
    step1("d1_rise_e3", 1'b1, 1'b0);
    raw_in1 = 6'd0;
    step1("d1_fall_e0", 1'b1, 1'b0);
    step1("d1_fall_e1", 1'b1, 1'b0);
    step1("d1_fall_e2", 1'b0, 1'b0);
    step1("d1_fall_e3", 1'b0, 1'b0);

    // One-clock glitch passes straight through a 1-cycle debouncer
    raw_in1 = 6'b000001;
    step1("d1_glitch_e0", 1'b0, 1'b0);
    raw_in1 = 6'd0;
    step1("d1_glitch_e1", 1'b0, 1'b0);
    step1("d1_glitch_e2", 1'b1, 1'b1);
    step1("d1_glitch_e3", 1'b0, 1'b0);
    step1("d1_glitch_e4", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
